// File: rtl/fetch_prefetch.sv
// Instruction prefetch unit: issues word-aligned fetches, buffers in-order responses
// in a FIFO toward decode, and flushes/refetches on redirect. Optional FETCH_PERF_CNT_EN adds perf counters.
module fetch_prefetch #(
  parameter int unsigned     XLEN            = 32,
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_link,
  output logic [XLEN-1:0] out_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     redirect_count,
  output logic [31:0]     stall_count
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTSTANDING);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0] pc_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_d [DEPTH];
  logic [XLEN-1:0] link_mem_q [DEPTH];
  logic [XLEN-1:0] link_mem_d [DEPTH];
  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic [XLEN-1:0] instr_mem_d [DEPTH];
  logic            req_fire, rsp_take, push, pop, credit_ok;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_d        = drop_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    pc_mem_d      = pc_mem_q;
    link_mem_d    = link_mem_q;
    instr_mem_d   = instr_mem_q;
    push          = 1'b0;

    // Dropped requests still occupy memory slots, so they count against both limits.
    credit_ok     = ((CW + 1)'(count_q) + (CW + 1)'(outstanding_q)) < DEPTH_C;
    mem_req_valid = !reset && !redirect && (outstanding_q < MAXO_C) && credit_ok;
    mem_req_addr  = fetch_pc_q;
    req_fire      = mem_req_valid && mem_req_ready;
    rsp_take      = mem_rsp_valid && (outstanding_q != '0);
    out_valid     = !reset && !redirect && (count_q != '0);
    pop           = out_valid && out_ready;

    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_take);
    if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);

    if (redirect) begin
      fetch_pc_d = {redirect_target[XLEN-1:2], 2'b00};
      rsp_pc_d   = {redirect_target[XLEN-1:2], 2'b00};
      drop_d     = outstanding_q - CW'(rsp_take);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (rsp_take) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          push                  = 1'b1;
          pc_mem_d[wr_ptr_q]    = rsp_pc_q;
          link_mem_d[wr_ptr_q]  = rsp_pc_q + XLEN'(4);
          instr_mem_d[wr_ptr_q] = mem_rsp_data;
          wr_ptr_d              = wr_ptr_q + PW'(1);
          rsp_pc_d              = rsp_pc_q + XLEN'(4);
        end
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  assign out_pc    = pc_mem_q[rd_ptr_q];
  assign out_link  = link_mem_q[rd_ptr_q];
  assign out_instr = instr_mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        link_mem_q[i]  <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      pc_mem_q      <= pc_mem_d;
      link_mem_q    <= link_mem_d;
      instr_mem_q   <= instr_mem_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] redirect_count_q, redirect_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    redirect_count_d = redirect_count_q;
    stall_count_d    = stall_count_q;
    if (redirect && (redirect_count_q != '1)) redirect_count_d = redirect_count_q + 32'd1;
    if (out_valid && !out_ready && (stall_count_q != '1)) stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_count_q <= '0;
      stall_count_q    <= '0;
    end else begin
      redirect_count_q <= redirect_count_d;
      stall_count_q    <= stall_count_d;
    end
  end

  assign redirect_count = redirect_count_q;
  assign stall_count    = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// Self-checking bench for fetch_prefetch: queue-based reference model plus directed scenarios,
// and a second instance with RESET_PC near the top of the address space.
module tb_fetch_prefetch;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        reset, mem_req_ready, mem_rsp_valid, redirect, out_ready;
  logic [31:0] mem_rsp_data, redirect_target;
  logic        mem_req_valid, out_valid;
  logic [31:0] mem_req_addr, out_pc, out_link, out_instr;
  logic        w_req_valid, w_rsp_valid, w_out_valid;
  logic [31:0] w_req_addr, w_rsp_data, w_out_pc, w_out_link, w_out_instr;
  logic        one = 1'b1, zero = 1'b0;
  logic [31:0] zero32 = '0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] redirect_count, stall_count, w_redirect_count, w_stall_count;
`endif

  always #5 clk = ~clk;

  fetch_prefetch #(.XLEN(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .redirect(redirect), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_link(out_link), .out_instr(out_instr)
`ifdef FETCH_PERF_CNT_EN
    , .redirect_count(redirect_count), .stall_count(stall_count)
`endif
  );

  fetch_prefetch #(.XLEN(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(reset),
    .mem_req_valid(w_req_valid), .mem_req_addr(w_req_addr), .mem_req_ready(one),
    .mem_rsp_valid(w_rsp_valid), .mem_rsp_data(w_rsp_data),
    .redirect(zero), .redirect_target(zero32),
    .out_valid(w_out_valid), .out_ready(one),
    .out_pc(w_out_pc), .out_link(w_out_link), .out_instr(w_out_instr)
`ifdef FETCH_PERF_CNT_EN
    , .redirect_count(w_redirect_count), .stall_count(w_stall_count)
`endif
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  ent_t        mq[$];
  mreq_t       memq[$];
  logic [31:0] m_fetch, m_rsp;
  int          m_out, m_drop, m_redir, m_stall;
  int          cyc, lat;
  bit          stray, p_rv, p_ov, w_fire;
  logic [31:0] w_addr;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not seen within cycle budget", name);
  endtask

  // Negedge: predict this cycle's outputs from the model and compare.
  task automatic sample();
    @(negedge clk);
    p_rv = !reset && !redirect && (m_out < MAXO) && ((mq.size() + m_out) < DEPTH);
    p_ov = !reset && !redirect && (mq.size() != 0);
    if (!reset) begin
      chk("mem_req_valid", mem_req_valid, p_rv);
      if (p_rv) chk("mem_req_addr", mem_req_addr, m_fetch);
      chk("out_valid", out_valid, p_ov);
      if (p_ov) begin
        chk("out_pc", out_pc, mq[0].pc);
        chk("out_link", out_link, mq[0].pc + 32'd4);
        chk("out_instr", out_instr, mq[0].instr);
      end
`ifdef FETCH_PERF_CNT_EN
      chk("redirect_count", redirect_count, m_redir);
      chk("stall_count", stall_count, m_stall);
`endif
    end
    w_fire = w_req_valid;
    w_addr = w_req_addr;
  endtask

  // Posedge: advance the model and memory by one cycle, then drive responses.
  task automatic advance();
    bit    fire, take, pop;
    ent_t  de;
    mreq_t dm;
    @(posedge clk);
    #1;
    if (reset) begin
      mq.delete();
      memq.delete();
      m_fetch = 32'h0; m_rsp = 32'h0;
      m_out = 0; m_drop = 0; m_redir = 0; m_stall = 0;
    end else begin
      fire = p_rv && mem_req_ready;
      take = mem_rsp_valid && (m_out > 0);
      pop  = p_ov && out_ready;
      if (redirect) m_redir++;
      if (p_ov && !out_ready) m_stall++;
      if (take) dm = memq.pop_front();
      if (redirect) begin
        m_drop  = m_out - int'(take);
        m_out   = m_out - int'(take);
        mq.delete();
        m_fetch = {redirect_target[31:2], 2'b00};
        m_rsp   = {redirect_target[31:2], 2'b00};
      end else begin
        if (pop) de = mq.pop_front();
        if (take) begin
          if (m_drop > 0) m_drop--;
          else begin
            mq.push_back('{m_rsp, mem_rsp_data});
            m_rsp = m_rsp + 32'd4;
          end
        end
        if (fire) begin
          memq.push_back('{m_fetch, cyc + lat});
          m_fetch = m_fetch + 32'd4;
        end
        m_out = m_out + int'(fire) - int'(take);
      end
    end
    cyc++;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = ~memq[0].addr;
    end else if (stray && memq.size() == 0) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'hDEAD_BEEF;
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
    w_rsp_valid = w_fire && !reset;
    w_rsp_data  = ~w_addr;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      advance();
    end
  endtask

  task automatic wait_req(input string name, input logic [31:0] exp);
    bit found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      sample();
      if (mem_req_valid) begin
        chk(name, mem_req_addr, exp);
        found = 1;
      end
      advance();
    end
    if (!found) timeout(name);
  endtask

  task automatic wait_out(input string name, input logic [31:0] exp_pc);
    bit found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      sample();
      if (out_valid) begin
        chk(name, out_pc, exp_pc);
        chk({name, "_instr"}, out_instr, ~exp_pc);
        found = 1;
      end
      advance();
    end
    if (!found) timeout(name);
  endtask

  initial begin
    bit found;
    reset = 1'b1; redirect = 1'b0; redirect_target = '0;
    mem_req_ready = 1'b1; out_ready = 1'b1; stray = 0;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    w_rsp_valid = 1'b0; w_rsp_data = '0;
    cyc = 0; lat = 1; w_fire = 0; w_addr = '0;
    m_fetch = '0; m_rsp = '0; m_out = 0; m_drop = 0; m_redir = 0; m_stall = 0;

    run(2);
    sample();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_link", out_link, 0);
    chk("rst_out_instr", out_instr, 0);
    advance();
    reset = 1'b0;

    // Cycles 1..4 after release: literal pipeline timing, both instances.
    sample();
    chk("c1_req_valid", mem_req_valid, 1);
    chk("c1_req_addr", mem_req_addr, 32'h0);
    chk("w_c1_addr", w_req_addr, 32'hFFFF_FFF8);
    advance();
    sample();
    chk("c2_req_addr", mem_req_addr, 32'h4);
    chk("c2_out_valid", out_valid, 0);
    chk("w_c2_addr", w_req_addr, 32'hFFFF_FFFC);
    advance();
    sample();
    chk("c3_out_valid", out_valid, 1);
    chk("c3_out_pc", out_pc, 32'h0);
    chk("c3_out_link", out_link, 32'h4);
    chk("c3_req_addr", mem_req_addr, 32'h8);
    chk("w_c3_addr", w_req_addr, 32'h0);
    chk("w_c3_out_pc", w_out_pc, 32'hFFFF_FFF8);
    advance();
    sample();
    chk("w_c4_out_pc", w_out_pc, 32'hFFFF_FFFC);
    chk("w_c4_out_link", w_out_link, 32'h0);
    advance();
    run(4);

    // Decode stall: queue fills, requests stop, drain in order afterwards.
    out_ready = 1'b0;
    run(9);
    sample();
    chk("stall_model_fill", mq.size(), 4);
    chk("stall_req_valid", mem_req_valid, 0);
    chk("stall_out_valid", out_valid, 1);
    advance();
    out_ready = 1'b1;
    run(8);

    // Redirect with two stale requests in flight.
    lat = 4;
    run(3);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (m_out == 2 && !mem_rsp_valid) found = 1;
      else begin sample(); advance(); end
    end
    if (!found) timeout("find_two_outstanding");
    redirect = 1'b1; redirect_target = 32'h103;
    sample();
    advance();
    redirect = 1'b0;
    chk("drop_model", m_drop, 2);
    wait_req("redir_first_addr", 32'h100);
    wait_out("redir_first_out", 32'h100);
    run(6);

    // Redirect coinciding with a response and a would-be pop.
    lat = 1;
    run(4);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (mq.size() != 0 && mem_rsp_valid) found = 1;
      else begin sample(); advance(); end
    end
    if (!found) timeout("find_rsp_pop");
    redirect = 1'b1; redirect_target = 32'h200;
    sample();
    chk("same_cyc_out_valid", out_valid, 0);
    advance();
    redirect = 1'b0;
    sample();
    chk("after_redir_out_valid", out_valid, 0);
    advance();
    wait_out("same_cyc_next_out", 32'h200);

    // Pending request withdrawn by redirect.
    mem_req_ready = 1'b0;
    run(4);
    redirect = 1'b1; redirect_target = 32'h3000_000A;
    sample();
    advance();
    redirect = 1'b0; mem_req_ready = 1'b1;
    wait_req("withdraw_first_addr", 32'h3000_0008);
    run(6);

    // Mixed backpressure and latency, including a wrap across 2^32.
    for (int i = 0; i < 40; i++) begin
      out_ready     = (i % 3) != 0;
      mem_req_ready = (i % 4) != 1;
      lat           = 1 + (i % 3);
      redirect        = (i == 20);
      redirect_target = 32'hFFFF_FFF9;
      run(1);
    end
    redirect = 1'b0; out_ready = 1'b1; mem_req_ready = 1'b1; lat = 1;
    run(10);

    // Reset overrides a simultaneous redirect; stray response afterwards is ignored.
    reset = 1'b1; redirect = 1'b1; redirect_target = 32'h400;
    run(1);
    redirect = 1'b0;
    sample();
    chk("rst2_out_pc", out_pc, 0);
    chk("rst2_out_link", out_link, 0);
    stray = 1;
    advance();
    reset = 1'b0;
    sample();
    chk("rst2_c1_addr", mem_req_addr, 32'h0);
    stray = 0;
    advance();
    sample();
    chk("stray_ignored", out_valid, 0);
    advance();

    // 5 stall cycles and 3 redirects since the last reset.
    run(4);
    out_ready = 1'b0;
    run(5);
    out_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      redirect = 1'b1; redirect_target = 32'h800 + 32'(r * 64);
      run(1);
      redirect = 1'b0;
      run(2);
    end
    sample();
`ifdef FETCH_PERF_CNT_EN
    chk("perf_redirects", redirect_count, 32'd3);
    chk("perf_stalls", stall_count, 32'd5);
`endif
    advance();
    reset = 1'b1;
    run(1);
    sample();
`ifdef FETCH_PERF_CNT_EN
    chk("perf_rst_redirects", redirect_count, 32'd0);
    chk("perf_rst_stalls", stall_count, 32'd0);
`endif
    advance();
    reset = 1'b0;
    run(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
